// File: rtl/clk_meter_pkg.sv
// Shared types and widths for the clock period meter.
package clk_meter_pkg;

   localparam int CNT_W = 28;
   localparam int RUN_W = 4;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   // Unsigned inclusive window test used for the in-range decision.
   function automatic logic in_window(input logic [CNT_W-1:0] val,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for the slow clock under test, plus a third flop for rise detection.
module edge_sync (
   input  logic clk_in,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic level
);

   logic sync1_r;
   logic sync2_r;
   logic sync3_r;

   // Synchronizer chain; sync3_r only serves the edge detector.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
      end else begin
         sync1_r <= d;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
      end
   end

   assign rise  = sync2_r & ~sync3_r;
   assign level = sync2_r;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of sig_in in clk_in cycles, flags range, lock and timeout.
// Optional high-time output enabled by defining CLK_PERIOD_METER_DUTY_EN.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int MIN_PERIOD  = 99_000_000,
   parameter int MAX_PERIOD  = 101_000_000,
   parameter int TIMEOUT_CYC = 150_000_000,
   parameter int LOCK_COUNT  = 3
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             in_range,
   output logic             locked,
   output logic             timeout
`ifdef CLK_PERIOD_METER_DUTY_EN
   ,
   output logic [CNT_W-1:0] high_out
`endif
);

   localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_COUNT);
   localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [RUN_W-1:0] run_r;
   logic             rise_s;
   logic             level_s;
   logic             edge_s;
   logic             in_win_s;
   logic [RUN_W-1:0] run_inc_s;
`ifdef CLK_PERIOD_METER_DUTY_EN
   logic [CNT_W-1:0] high_cnt_r;
`endif

   edge_sync u_edge_sync (
      .clk_in (clk_in),
      .rst    (rst),
      .d      (sig_in),
      .rise   (rise_s),
      .level  (level_s)
   );

   // A rise always coincides with a high synchronized level; qualifying keeps the two consistent.
   assign edge_s = rise_s & level_s;

   // Range decision and saturating lock-run increment for the period just closed.
   always_comb begin
      in_win_s  = 1'b0;
      run_inc_s = run_r;
      in_win_s  = in_window(cnt_r, MIN_C, MAX_C);
      if (run_r == LOCK_C) begin
         run_inc_s = run_r;
      end else begin
         run_inc_s = run_r + RUN_ONE;
      end
   end

   // Measurement FSM with all status outputs registered.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         run_r        <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
         in_range     <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
`ifdef CLK_PERIOD_METER_DUTY_EN
         high_cnt_r   <= '0;
         high_out     <= '0;
`endif
      end else begin
         period_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               // First edge after reset or timeout is a reference only.
               if (edge_s) begin
                  cnt_r   <= CNT_ONE;
                  state_r <= MEASURE;
                  timeout <= 1'b0;
`ifdef CLK_PERIOD_METER_DUTY_EN
                  high_cnt_r <= CNT_ONE;
`endif
               end
            end
            MEASURE: begin
               if (edge_s) begin
                  period_out   <= cnt_r;
                  period_valid <= 1'b1;
                  cnt_r        <= CNT_ONE;
                  in_range     <= in_win_s;
`ifdef CLK_PERIOD_METER_DUTY_EN
                  high_out     <= high_cnt_r;
                  high_cnt_r   <= CNT_ONE;
`endif
                  if (in_win_s) begin
                     run_r  <= run_inc_s;
                     locked <= (run_inc_s == LOCK_C);
                  end else begin
                     run_r  <= '0;
                     locked <= 1'b0;
                  end
               end else if (cnt_r == TIMEOUT_C) begin
                  state_r  <= IDLE;
                  timeout  <= 1'b1;
                  locked   <= 1'b0;
                  run_r    <= '0;
                  in_range <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
`ifdef CLK_PERIOD_METER_DUTY_EN
                  high_cnt_r <= high_cnt_r + {{(CNT_W-1){1'b0}}, level_s};
`endif
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
